// File: rtl/inst_fetch_if_pkg.sv
// Shared constants for the instruction-fetch stage: FSM state encodings,
// exception bit index and the stall / zero-word literals.
package inst_fetch_if_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

    localparam int EXC_ADEL_BIT = 4;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_if_out_buf.sv
// Output holding register of the fetch stage: loads a completed fetch,
// keeps it while the decode stage is stalled, otherwise clears to empty.
module if_out_buf
    import inst_fetch_if_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EXC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              keep_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [EXC_W-1:0]  except_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [EXC_W-1:0]  except_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] inst_q;
    logic [EXC_W-1:0]  except_q;
    logic              valid_q;

    // Load wins over keep; anything not loaded or kept is dropped so a flush empties the slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            inst_q   <= DATA_W'(ZeroWord);
            except_q <= '0;
            valid_q  <= 1'b0;
        end else if (load_i) begin
            pc_q     <= pc_i;
            inst_q   <= inst_i;
            except_q <= except_i;
            valid_q  <= 1'b1;
        end else if (!keep_i) begin
            pc_q     <= '0;
            inst_q   <= DATA_W'(ZeroWord);
            except_q <= '0;
            valid_q  <= 1'b0;
        end
    end

    assign pc_o     = pc_q;
    assign inst_o   = inst_q;
    assign except_o = except_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/inst_fetch_if.sv
// Instruction-fetch stage: turns the registered PC into one outstanding bus fetch
// and hands the word to IF/ID. Define IF_ADEL_CHECK_EN to trap misaligned PCs (AdEL).
module inst_fetch_if
    import inst_fetch_if_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EXC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pc_valid,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_inst,
    output logic              o_valid,
    output logic [EXC_W-1:0]  o_except,
    output logic              stallreq
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pcAligned;
    logic              fetchTry, issue, adelHit, capture, keep;
    logic [EXC_W-1:0]  excAdel;
    logic              unusedStall;

`ifdef IF_ADEL_CHECK_EN
    assign pcAligned = (i_pc[1:0] == 2'b00);
`else
    assign pcAligned = 1'b1;
`endif

    always_comb begin
        excAdel               = '0;
        excAdel[EXC_ADEL_BIT] = 1'b1;
    end

    // Reset also gates the combinational request so nothing leaks onto the bus while held
    assign fetchTry = reset && (state_q == ST_IDLE) && i_pc_valid && !flush && !stall[1];
    assign issue    = fetchTry && pcAligned;
    assign adelHit  = fetchTry && !pcAligned;
    assign capture  = (state_q == ST_WAIT) && inst_data_ok && !flush;
    assign keep     = (state_q == ST_HOLD) && stall[2] && !flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    pc_d    = i_pc;
                    state_d = inst_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                // An address accepted alongside the flush still owes a data beat, so drain it
                if (flush)
                    state_d = inst_addr_ok ? ST_DROP : ST_IDLE;
                else if (inst_addr_ok)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (inst_data_ok)
                    state_d = (flush || !stall[2]) ? ST_IDLE : ST_HOLD;
                else if (flush)
                    state_d = ST_DROP;
            end
            ST_HOLD: begin
                if (flush || !stall[2])
                    state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (inst_data_ok)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign inst_req = issue || (state_q == ST_REQ);

    always_comb begin
        inst_addr = '0;
        if (issue)
            inst_addr = {i_pc[ADDR_W-1:2], 2'b00};
        else if (state_q == ST_REQ)
            inst_addr = {pc_q[ADDR_W-1:2], 2'b00};
    end

    assign stallreq = (issue || (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                       (state_q == ST_DROP)) ? Stop : NoStop;

    assign unusedStall = ^{stall[5:3], stall[0]};

    if_out_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W)
    ) u_out_buf (
        .clk      (clk),
        .reset    (reset),
        .load_i   (capture || adelHit),
        .keep_i   (keep),
        .pc_i     (adelHit ? i_pc : pc_q),
        .inst_i   (adelHit ? DATA_W'(ZeroWord) : inst_rdata),
        .except_i (adelHit ? excAdel : '0),
        .pc_o     (o_pc),
        .inst_o   (o_inst),
        .except_o (o_except),
        .valid_o  (o_valid)
    );

endmodule
